peak_frame_serializer: RTL and testbench

Parametrised successor to the fixed 16-peak parallel-in/serial-out stage: snapshots a vector of N spectral-peak entries, drops empty entries and emits a framed word stream on a valid/ready interface. Each frame is a header, count, frequency bins and checksum. Sits between the peak-finding core and the clock-crossing FIFO feeding the SPI link. A one-frame pending buffer absorbs a new peak set while the previous frame drains; overruns are counted, never silently lost.

---
 rtl/peak_frame_serializer.sv | 223 ++++++++++++++++++++++
 tb/tb_peak_frame_serializer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/peak_frame_serializer.sv
// Peak snapshot to framed word stream serializer.
// Frame: header, count, kept bins, checksum.
module peak_frame_serializer #(
  parameter int N_PEAKS = 16,
  parameter int IN_W = 25,
  parameter int BIN_W = 9,
  parameter logic [BIN_W-1:0] HEADER = '1,
  parameter bit SKIP_ZERO = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [IN_W-1:0]  peaks [N_PEAKS],
  output logic [BIN_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             pending,
  output logic             drop,
  output logic [7:0]       drop_count
);

  localparam int IW = $clog2(N_PEAKS);

  typedef enum logic [2:0] {
    S_IDLE, S_HEAD, S_COUNT, S_DATA, S_CHECK
  } state_t;

  typedef logic [BIN_W-1:0] word_t;

  state_t state, state_n;
  logic [IW-1:0] idx, idx_n;

  word_t act_bin [N_PEAKS];
  word_t act_bin_n [N_PEAKS];
  word_t pnd_bin [N_PEAKS];
  word_t pnd_bin_n [N_PEAKS];
  word_t cap_bin [N_PEAKS];

  logic [N_PEAKS-1:0] act_keep, act_keep_n;
  logic [N_PEAKS-1:0] pnd_keep, pnd_keep_n;
  logic [N_PEAKS-1:0] cap_keep;

  word_t act_cnt, act_cnt_n, act_sum, act_sum_n;
  word_t pnd_cnt, pnd_cnt_n, pnd_sum, pnd_sum_n;
  word_t cap_cnt, cap_sum;

  logic       pnd_n, drop_n, valid_n;
  logic [7:0] dc_n;
  word_t      data_n;
  logic       acc, last;

  // Snapshot view of the incoming peaks: bins, keep mask, count, checksum
  always_comb begin
    cap_cnt  = '0;
    cap_sum  = '0;
    cap_keep = '0;
    for (int i = 0; i < N_PEAKS; i++) begin
      cap_bin[i]  = peaks[i][BIN_W-1:0];
      cap_keep[i] = !SKIP_ZERO ||
                    (peaks[i][IN_W-1:BIN_W] != '0);
      if (cap_keep[i]) begin
        cap_cnt = cap_cnt + word_t'(1);
        cap_sum = cap_sum ^ cap_bin[i];
      end
    end
    cap_sum = cap_sum ^ cap_cnt;
  end

  // Frame sequencing and active/pending buffer management
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    act_bin_n  = act_bin;
    act_keep_n = act_keep;
    act_cnt_n  = act_cnt;
    act_sum_n  = act_sum;
    pnd_bin_n  = pnd_bin;
    pnd_keep_n = pnd_keep;
    pnd_cnt_n  = pnd_cnt;
    pnd_sum_n  = pnd_sum;
    pnd_n      = pending;
    drop_n     = 1'b0;
    dc_n       = drop_count;
    acc        = out_valid && out_ready;
    last       = (idx == IW'(N_PEAKS - 1));

    unique case (state)
      S_IDLE: begin
        if (load) begin
          act_bin_n  = cap_bin;
          act_keep_n = cap_keep;
          act_cnt_n  = cap_cnt;
          act_sum_n  = cap_sum;
          state_n    = S_HEAD;
        end
      end
      S_HEAD: begin
        if (acc) state_n = S_COUNT;
      end
      S_COUNT: begin
        if (acc) begin
          state_n = S_DATA;
          idx_n   = '0;
        end
      end
      S_DATA: begin
        if (!out_valid || out_ready) begin
          if (last) state_n = S_CHECK;
          else      idx_n   = idx + IW'(1);
        end
      end
      S_CHECK: begin
        if (acc) begin
          if (pending) begin
            act_bin_n  = pnd_bin;
            act_keep_n = pnd_keep;
            act_cnt_n  = pnd_cnt;
            act_sum_n  = pnd_sum;
            pnd_n      = 1'b0;
            state_n    = S_HEAD;
          end else if (load) begin
            act_bin_n  = cap_bin;
            act_keep_n = cap_keep;
            act_cnt_n  = cap_cnt;
            act_sum_n  = cap_sum;
            state_n    = S_HEAD;
          end else begin
            state_n    = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    // A busy-time load goes to pending, or is dropped if pending is full.
    // A load taken straight into active at CHECK accept is excluded.
    if (load && state != S_IDLE &&
        !(state == S_CHECK && acc && !pending)) begin
      if (!pnd_n) begin
        pnd_bin_n  = cap_bin;
        pnd_keep_n = cap_keep;
        pnd_cnt_n  = cap_cnt;
        pnd_sum_n  = cap_sum;
        pnd_n      = 1'b1;
      end else begin
        drop_n = 1'b1;
        if (drop_count != 8'hFF) dc_n = drop_count + 8'd1;
      end
    end
  end

  // Registered outputs derived from the next state, so they stay
  // stable for as long as the state holds under backpressure
  always_comb begin
    valid_n = 1'b0;
    data_n  = '0;
    unique case (state_n)
      S_IDLE: begin
        valid_n = 1'b0;
      end
      S_HEAD: begin
        valid_n = 1'b1;
        data_n  = HEADER;
      end
      S_COUNT: begin
        valid_n = 1'b1;
        data_n  = act_cnt_n;
      end
      S_DATA: begin
        valid_n = act_keep_n[idx_n];
        data_n  = act_bin_n[idx_n];
      end
      S_CHECK: begin
        valid_n = 1'b1;
        data_n  = act_sum_n;
      end
      default: valid_n = 1'b0;
    endcase
  end

  // State, buffers and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      idx        <= '0;
      act_keep   <= '0;
      act_cnt    <= '0;
      act_sum    <= '0;
      pnd_keep   <= '0;
      pnd_cnt    <= '0;
      pnd_sum    <= '0;
      pending    <= 1'b0;
      drop       <= 1'b0;
      drop_count <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      busy       <= 1'b0;
      for (int i = 0; i < N_PEAKS; i++) begin
        act_bin[i] <= '0;
        pnd_bin[i] <= '0;
      end
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      act_bin    <= act_bin_n;
      act_keep   <= act_keep_n;
      act_cnt    <= act_cnt_n;
      act_sum    <= act_sum_n;
      pnd_bin    <= pnd_bin_n;
      pnd_keep   <= pnd_keep_n;
      pnd_cnt    <= pnd_cnt_n;
      pnd_sum    <= pnd_sum_n;
      pending    <= pnd_n;
      drop       <= drop_n;
      drop_count <= dc_n;
      out_valid  <= valid_n;
      out_data   <= data_n;
      busy       <= (state_n != S_IDLE);
    end
  end

endmodule

// File: tb/tb_peak_frame_serializer.sv
// Randomized bench for peak_frame_serializer.
// Reference: per-load frame queues and an occupancy count.
module tb_peak_frame_serializer;

  localparam int N = 4;
  localparam logic [8:0] HDR = 9'h1FF;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld, ld1, rdy;
  logic [24:0] pk [N];

  logic [8:0] od0, od1;
  logic       ov0, ov1, busy0, busy1;
  logic       pend0, pend1, drop0, drop1;
  logic [7:0] dc0, dc1;

  int n_vec = 0;
  int n_err = 0;

  logic [8:0] wq [$];
  int         flen [$];
  logic [8:0] fr [$];
  int         outst = 0;
  int         mdc = 0;

  bit         vt [8] = '{1, 1, 1, 0, 1, 1, 1, 0};
  logic [8:0] dt [8] = '{9'h1FF, 9'h003, 9'h010, 9'h000,
                         9'h030, 9'h040, 9'h063, 9'h000};

  peak_frame_serializer #(
    .N_PEAKS(N), .IN_W(25), .BIN_W(9),
    .HEADER(HDR), .SKIP_ZERO(1'b1)
  ) dut0 (
    .clk(clk), .reset(reset), .load(ld), .peaks(pk),
    .out_data(od0), .out_valid(ov0), .out_ready(rdy),
    .busy(busy0), .pending(pend0), .drop(drop0),
    .drop_count(dc0)
  );

  peak_frame_serializer #(
    .N_PEAKS(N), .IN_W(25), .BIN_W(9),
    .HEADER(HDR), .SKIP_ZERO(1'b0)
  ) dut1 (
    .clk(clk), .reset(reset), .load(ld1), .peaks(pk),
    .out_data(od1), .out_valid(ov1), .out_ready(1'b1),
    .busy(busy1), .pending(pend1), .drop(drop1),
    .drop_count(dc1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic make_frame(input bit skip);
    logic [8:0] c, s;
    logic [8:0] b [$];
    c = 0;
    s = 0;
    b.delete();
    for (int i = 0; i < N; i++) begin
      if (!skip || pk[i][24:9] != 16'h0) begin
        c = c + 9'd1;
        s = s ^ pk[i][8:0];
        b.push_back(pk[i][8:0]);
      end
    end
    fr.delete();
    fr.push_back(HDR);
    fr.push_back(c);
    foreach (b[j]) fr.push_back(b[j]);
    fr.push_back(c ^ s);
  endtask

  task automatic rand_peaks();
    for (int i = 0; i < N; i++) begin
      pk[i][24:9] = ($urandom_range(0, 1) != 0) ?
                    16'($urandom) : 16'h0;
      pk[i][8:0]  = 9'($urandom);
    end
  endtask

  task automatic model_clear();
    wq.delete();
    flen.delete();
    outst = 0;
    mdc = 0;
  endtask

  // One clock: apply inputs, update model, check after edge
  task automatic step(input bit l, input bit r);
    logic       held, comp, xd;
    logic [8:0] hd;
    ld   = l;
    rdy  = r;
    held = ov0 && !r;
    hd   = od0;
    comp = 1'b0;
    xd   = 1'b0;
    if (ov0 && r) begin
      chk("word_avail", wq.size() > 0, 1);
      if (wq.size() > 0) begin
        chk("word", od0, wq.pop_front());
        flen[0] = flen[0] - 1;
        if (flen[0] == 0) begin
          void'(flen.pop_front());
          outst--;
          comp = 1'b1;
        end
      end
    end
    if (l) begin
      if (outst < 2) begin
        make_frame(1'b1);
        foreach (fr[j]) wq.push_back(fr[j]);
        flen.push_back(fr.size());
        outst++;
      end else begin
        xd = 1'b1;
        if (mdc < 255) mdc++;
      end
    end
    @(posedge clk);
    #1;
    ld = 1'b0;
    chk("drop", drop0, xd);
    chk("drop_count", dc0, mdc);
    chk("busy", busy0, outst > 0);
    chk("pending", pend0, outst == 2);
    if (outst == 0) chk("idle_valid", ov0, 0);
    if (held) begin
      chk("hold_valid", ov0, 1);
      chk("hold_data", od0, hd);
    end
    if (comp && outst > 0) begin
      chk("b2b_valid", ov0, 1);
      chk("b2b_hdr", od0, HDR);
    end
  endtask

  initial begin
    reset = 1'b1;
    ld    = 1'b0;
    ld1   = 1'b0;
    rdy   = 1'b0;
    for (int i = 0; i < N; i++) pk[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", od0, 0);
    chk("rst_valid", ov0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_pend", pend0, 0);
    chk("rst_drop", drop0, 0);
    chk("rst_dc", dc0, 0);
    chk("rst1_valid", ov1, 0);
    chk("rst1_pend", pend1 | drop1 | busy1, 0);
    chk("rst1_dc", {dc1, od1}, 0);
    reset = 1'b0;

    // Directed frame with one skipped entry
    pk[0] = {16'd5, 9'h010};
    pk[1] = {16'd0, 9'h020};
    pk[2] = {16'd7, 9'h030};
    pk[3] = {16'd1, 9'h040};
    step(1, 1);
    for (int k = 0; k < 8; k++) begin
      chk("plan_valid", ov0, vt[k]);
      if (vt[k]) chk("plan_data", od0, dt[k]);
      step(0, 1);
    end

    // Same frame under pseudo-random backpressure
    step(1, 1);
    repeat (30) step(0, $urandom_range(0, 1) != 0);

    // Overrun: pending then drop, back-to-back drain
    rand_peaks();
    step(1, 1);
    rand_peaks();
    step(1, 1);
    chk("ovr_pend", pend0, 1);
    rand_peaks();
    step(1, 1);
    chk("ovr_drop", drop0, 1);
    repeat (20) step(0, 1);

    // All-zero magnitudes, both skip modes
    for (int i = 0; i < N; i++)
      pk[i] = {16'h0, 9'(9'h010 * (i + 1))};
    ld1 = 1'b1;
    step(1, 1);
    ld1 = 1'b0;
    make_frame(1'b0);
    for (int k = 0; k < 7; k++) begin
      chk("sz0_valid", ov1, 1);
      chk("sz0_data", od1, fr[k]);
      step(0, 1);
    end
    chk("sz0_idle", busy1, 0);
    repeat (2) step(0, 1);

    // Load coincident with CHECK accept
    rand_peaks();
    step(1, 1);
    repeat (6) step(0, 1);
    rand_peaks();
    step(1, 1);
    chk("coinc_hdr", od0, HDR);
    chk("coinc_drop", drop0, 0);
    repeat (10) step(0, 1);

    // Random traffic
    repeat (500) begin
      rand_peaks();
      step($urandom_range(0, 7) == 0,
           $urandom_range(0, 3) != 0);
    end
    repeat (30) step(0, 1);

    // Sustained overrun saturates drop_count
    rand_peaks();
    step(1, 1);
    repeat (300) step(1, 0);
    chk("dc_sat", dc0, 255);
    repeat (30) step(0, 1);

    // Reset in the middle of DATA
    rand_peaks();
    step(1, 1);
    step(0, 1);
    step(0, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", ov0, 0);
    chk("mid_rst_busy", busy0, 0);
    chk("mid_rst_pend", pend0, 0);
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b0;
    rand_peaks();
    step(1, 1);
    chk("post_rst_valid", ov0, 1);
    chk("post_rst_hdr", od0, HDR);
    repeat (20) step(0, 1);

    chk("drained", wq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
